// File: rtl/seq_signed_divider_if.sv
// Start/done handshake and operand/result bundle between the control FSM
// and the sequential signed divider.
interface seq_signed_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Multicycle signed restoring divider (MIPS DIV semantics): quotient to lo,
// remainder to hi, one quotient bit per cycle on operand magnitudes.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_signed_divider_if.slave   bus
);
  localparam int CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude as an unsigned value; the most negative input maps to itself.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    absVal = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic neg, input logic [WIDTH-1:0] v);
    applySign = neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  state_t           stateR, stateNext;
  logic [CntW-1:0]  countR, countNext;
  logic [WIDTH-1:0] quoR, quoNext;
  logic [WIDTH-1:0] remR, remNext;
  logic [WIDTH-1:0] dvsrR, dvsrNext;
  logic             signQR, signQNext;
  logic             signRR, signRNext;
  logic             busyR, busyNext;
  logic             doneR, doneNext;
  logic             divZeroR, divZeroNext;
  logic [WIDTH-1:0] hiR, hiNext;
  logic [WIDTH-1:0] loR, loNext;

  // Partial remainder is always below the divisor magnitude, so the shifted
  // {R,Q[msb]} fits in WIDTH+1 bits and bit WIDTH of the trial is its borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {remR, quoR[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsrR};

  // Next-state and datapath update for every register.
  always_comb begin
    stateNext   = stateR;
    countNext   = countR;
    quoNext     = quoR;
    remNext     = remR;
    dvsrNext    = dvsrR;
    signQNext   = signQR;
    signRNext   = signRR;
    busyNext    = busyR;
    doneNext    = 1'b0;
    divZeroNext = divZeroR;
    hiNext      = hiR;
    loNext      = loR;

    case (stateR)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            divZeroNext = 1'b1;
            doneNext    = 1'b1;
            stateNext   = IDLE;
          end else begin
            quoNext     = absVal(bus.dividend);
            dvsrNext    = absVal(bus.divisor);
            remNext     = {WIDTH{1'b0}};
            signQNext   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            signRNext   = bus.dividend[WIDTH-1];
            busyNext    = 1'b1;
            divZeroNext = 1'b0;
            countNext   = {CntW{1'b0}};
            stateNext   = RUN;
          end
        end else begin
          stateNext = IDLE;
        end
      end

      RUN: begin
        if (!trial[WIDTH]) begin
          remNext = trial[WIDTH-1:0];
          quoNext = {quoR[WIDTH-2:0], 1'b1};
        end else begin
          remNext = shifted[WIDTH-1:0];
          quoNext = {quoR[WIDTH-2:0], 1'b0};
        end
        if (countR == CntW'(WIDTH - 1)) begin
          stateNext = FIX;
        end else begin
          countNext = countR + {{(CntW-1){1'b0}}, 1'b1};
        end
      end

      FIX: begin
        loNext    = applySign(signQR, quoR);
        hiNext    = applySign(signRR, remR);
        doneNext  = 1'b1;
        busyNext  = 1'b0;
        stateNext = IDLE;
      end

      default: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR   <= IDLE;
      countR   <= {CntW{1'b0}};
      quoR     <= {WIDTH{1'b0}};
      remR     <= {WIDTH{1'b0}};
      dvsrR    <= {WIDTH{1'b0}};
      signQR   <= 1'b0;
      signRR   <= 1'b0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
      divZeroR <= 1'b0;
      hiR      <= {WIDTH{1'b0}};
      loR      <= {WIDTH{1'b0}};
    end else begin
      stateR   <= stateNext;
      countR   <= countNext;
      quoR     <= quoNext;
      remR     <= remNext;
      dvsrR    <= dvsrNext;
      signQR   <= signQNext;
      signRR   <= signRNext;
      busyR    <= busyNext;
      doneR    <= doneNext;
      divZeroR <= divZeroNext;
      hiR      <= hiNext;
      loR      <= loNext;
    end
  end

  assign bus.busy     = busyR;
  assign bus.done     = doneR;
  assign bus.div_zero = divZeroR;
  assign bus.hi       = hiR;
  assign bus.lo       = loR;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed plus random checks of seq_signed_divider against a truncating
// signed-division reference computed with 64-bit integer arithmetic.
module tb_seq_signed_divider;
  logic clk;
  logic reset;
  int   nAssert;
  int   nFail;
  logic [31:0] lastLo;
  logic [31:0] lastHi;

  seq_signed_divider_if #(.WIDTH(32)) bus ();

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit division avoids the most-negative / -1 overflow.
  task automatic refDiv(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endtask

  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Called at the first negedge after the accepting edge; returns at the done negedge.
  task automatic finishOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int injAt, input logic [31:0] ia, input logic [31:0] ib);
    int n;
    int bc;
    logic [31:0] eq;
    logic [31:0] er;
    logic zero;
    zero = (b == 32'd0);
    if (zero) begin
      eq = lastLo;
      er = lastHi;
    end else begin
      refDiv(a, b, eq, er);
    end
    n  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) bc++;
      if (n == injAt) begin
        bus.start    = 1'b1;
        bus.dividend = ia;
        bus.divisor  = ib;
      end else if (n == injAt + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, {31'd0, bus.done}, 32'd1);
    check({tag, " latency"}, n, zero ? 32'd0 : 32'd33);
    check({tag, " busycycles"}, bc, zero ? 32'd0 : 32'd33);
    check({tag, " lo"}, bus.lo, eq);
    check({tag, " hi"}, bus.hi, er);
    check({tag, " divzero"}, {31'd0, bus.div_zero}, {31'd0, zero});
    lastLo = eq;
    lastHi = er;
  endtask

  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b);
    startOp(a, b);
    finishOp(tag, a, b, -1, 32'd0, 32'd0);
    @(negedge clk);
    check({tag, " donepulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int sawDone;
    nAssert = 0;
    nFail   = 0;
    lastLo  = 32'd0;
    lastHi  = 32'd0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst divzero", {31'd0, bus.div_zero}, 32'd0);
    check("rst hi", bus.hi, 32'd0);
    check("rst lo", bus.lo, 32'd0);
    reset = 1'b0;

    runDiv("7/2", 32'd7, 32'd2);
    check("7/2 lit lo", bus.lo, 32'd3);
    check("7/2 lit hi", bus.hi, 32'd1);
    runDiv("-7/2", 32'hFFFF_FFF9, 32'd2);
    check("-7/2 lit lo", bus.lo, 32'hFFFF_FFFD);
    check("-7/2 lit hi", bus.hi, 32'hFFFF_FFFF);
    runDiv("7/-2", 32'd7, 32'hFFFF_FFFE);
    check("7/-2 lit hi", bus.hi, 32'd1);
    runDiv("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    check("-7/-2 lit lo", bus.lo, 32'd3);
    runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf lit lo", bus.lo, 32'h8000_0000);
    check("ovf lit hi", bus.hi, 32'd0);
    runDiv("min/1", 32'h8000_0000, 32'd1);

    runDiv("9/4", 32'd9, 32'd4);
    runDiv("5/0", 32'd5, 32'd0);
    check("5/0 lit lo", bus.lo, 32'd2);
    check("5/0 lit hi", bus.hi, 32'd1);

    // Reset in the middle of a divide.
    startOp(32'd100, 32'd7);
    sawDone = 0;
    repeat (10) begin
      if (bus.done === 1'b1) sawDone = 1;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("midrst busy", {31'd0, bus.busy}, 32'd0);
    check("midrst hi", bus.hi, 32'd0);
    check("midrst lo", bus.lo, 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (bus.done === 1'b1) sawDone = 1;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) sawDone = 1;
    end
    check("midrst nodone", sawDone, 32'd0);
    lastLo = 32'd0;
    lastHi = 32'd0;
    runDiv("100/7", 32'd100, 32'd7);

    // Start while busy is ignored; start in the done cycle is accepted.
    startOp(32'd50, 32'd5);
    finishOp("50/5", 32'd50, 32'd5, 5, 32'd9, 32'd3);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("50/5 donepulse", {31'd0, bus.done}, 32'd0);
    finishOp("9/3 chained", 32'd9, 32'd3, -1, 32'd0, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) begin
        rb = $urandom_range(1, 15);
        if ($urandom_range(0, 1) == 1) rb = 32'd0 - rb;
      end
      if (i % 5 == 0) ra = $urandom_range(0, 1000);
      if (rb == 32'd0) rb = 32'd1;
      runDiv($sformatf("rand%0d", i), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
